// File: rtl/mos6502_pkg.sv
// Shared 6502 sequencer types and default widths.
package mos6502_pkg;

  localparam int unsigned        SEQ_CYC_W      = 3;
  localparam int unsigned        SEQ_INST_W     = 8;
  localparam logic [7:0]         SEQ_BRK_OP     = 8'h00;
  localparam int unsigned        SEQ_WDOG_LIMIT = 16;

  // Interrupt source presented to the decoder for one service sequence
  typedef enum logic [1:0] {
    NONE = 2'd0,
    RST  = 2'd1,
    NMI  = 2'd2,
    IRQ  = 2'd3
  } int_src_t;

endpackage

// File: rtl/cycle_sequencer_nmi_edge_det.sv
// NMI synchroniser, rising-edge detect and pending flag (set beats clear).
module nmi_edge_det (
  input  logic clk,
  input  logic clr,
  input  logic nmi,
  input  logic clr_pend,
  output logic pend
);

  logic nmi_q;

  // Sample nmi every clock; a fresh edge always wins over a retire request
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      nmi_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      nmi_q <= nmi;
      if (nmi && !nmi_q) begin
        pend <= 1'b1;
      end else if (clr_pend) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction register, T-state counter and interrupt source latch for the
// 6502 decoder. Optional idle watchdog enabled by defining SEQ_WDOG_EN.
module cycle_sequencer
  import mos6502_pkg::*;
#(
  parameter int unsigned        CYC_W  = SEQ_CYC_W,
  parameter int unsigned        INST_W = SEQ_INST_W,
  parameter logic [INST_W-1:0]  BRK_OP = SEQ_BRK_OP
`ifdef SEQ_WDOG_EN
  , parameter int unsigned      WDOG_LIMIT = SEQ_WDOG_LIMIT
`endif
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rdy,
  input  logic [INST_W-1:0] dbus,
  input  logic              icyc,
  input  logic              scyc,
  input  logic              rcyc,
  input  logic              sinst,
  input  logic              irq,
  input  logic              nmi,
  input  logic              iflag,
  output logic [INST_W-1:0] inst,
  output logic [CYC_W-1:0]  cycle,
  output logic              rst_o,
  output logic              nmi_o,
  output logic              irq_o,
  output logic              sync,
  output logic              seq_err
);

  int_src_t          int_src, int_src_n;
  logic [CYC_W-1:0]  cycle_n;
  logic [INST_W-1:0] inst_n;
  logic [CYC_W:0]    cyc_sum;
  logic              rst_pend, rst_pend_n;
  logic              sync_n, seq_err_n;
  logic              nmi_pend, nmi_clr;
  logic              irq_req, wdog_trip;

  assign irq_req = irq && !iflag;

  nmi_edge_det u_nmi_edge_det (
    .clk      (clk),
    .clr      (clr),
    .nmi      (nmi),
    .clr_pend (nmi_clr),
    .pend     (nmi_pend)
  );

`ifdef SEQ_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);
  logic [WDOG_W-1:0] idle_cnt;

  assign wdog_trip = rdy && (idle_cnt == WDOG_W'(WDOG_LIMIT));

  // Count advancing clocks with no strobe; any strobe or a trip restarts it
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      idle_cnt <= '0;
    end else if (rdy) begin
      if (icyc || scyc || rcyc || wdog_trip) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + WDOG_W'(1);
      end
    end
  end
`else
  assign wdog_trip = 1'b0;
`endif

  // Next-state: strobe priority rcyc > scyc > icyc, everything frozen when !rdy
  always_comb begin
    int_src_n  = int_src;
    cycle_n    = cycle;
    inst_n     = inst;
    rst_pend_n = rst_pend;
    sync_n     = sync;
    seq_err_n  = seq_err;
    nmi_clr    = 1'b0;
    cyc_sum    = '0;
    if (rdy) begin
      sync_n = 1'b0;
      if (sinst) begin
        if (int_src == RST) rst_pend_n = 1'b0;
        if (int_src == NMI) nmi_clr = 1'b1;
      end
      if (wdog_trip) begin
        cycle_n    = '0;
        inst_n     = BRK_OP;
        int_src_n  = RST;
        rst_pend_n = 1'b1;
        seq_err_n  = 1'b1;
        sync_n     = 1'b1;
      end else if (rcyc) begin
        cycle_n = '0;
        sync_n  = 1'b1;
        if (rst_pend) begin
          inst_n    = BRK_OP;
          int_src_n = RST;
        end else if (nmi_pend) begin
          inst_n    = BRK_OP;
          int_src_n = NMI;
        end else if (irq_req) begin
          inst_n    = BRK_OP;
          int_src_n = IRQ;
        end else begin
          inst_n    = dbus;
          int_src_n = NONE;
        end
      end else if (scyc || icyc) begin
        cyc_sum = {1'b0, cycle} + (scyc ? (CYC_W+1)'(2) : (CYC_W+1)'(1));
        cycle_n = cyc_sum[CYC_W-1:0];
        if (cyc_sum[CYC_W]) seq_err_n = 1'b1;
      end
    end
  end

  // State and registered one-hot interrupt decodes
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      int_src  <= RST;
      cycle    <= '0;
      inst     <= BRK_OP;
      rst_pend <= 1'b1;
      sync     <= 1'b1;
      seq_err  <= 1'b0;
      rst_o    <= 1'b1;
      nmi_o    <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      int_src  <= int_src_n;
      cycle    <= cycle_n;
      inst     <= inst_n;
      rst_pend <= rst_pend_n;
      sync     <= sync_n;
      seq_err  <= seq_err_n;
      rst_o    <= (int_src_n == RST);
      nmi_o    <= (int_src_n == NMI);
      irq_o    <= (int_src_n == IRQ);
    end
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer; watchdog scenario built with SEQ_WDOG_EN.
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       clr, rdy, icyc, scyc, rcyc, sinst, irq, nmi, iflag;
  logic [7:0] dbus;
  logic [7:0] inst;
  logic [2:0] cycle;
  logic       rst_o, nmi_o, irq_o, sync, seq_err;

  int checks = 0;
  int passed = 0;

  cycle_sequencer dut (
    .clk(clk), .clr(clr), .rdy(rdy), .dbus(dbus), .icyc(icyc), .scyc(scyc),
    .rcyc(rcyc), .sinst(sinst), .irq(irq), .nmi(nmi), .iflag(iflag),
    .inst(inst), .cycle(cycle), .rst_o(rst_o), .nmi_o(nmi_o), .irq_o(irq_o),
    .sync(sync), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; rdy = 1'b1; icyc = 0; scyc = 0; rcyc = 0; sinst = 0;
    irq = 0; nmi = 0; iflag = 1; dbus = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rst_o !== 1'b1) $display("FAIL reset_hold_rst_o: got %b want 1", rst_o); else passed++;
    clr = 1'b0;
    checks++; if (inst !== 8'h00) $display("FAIL reset_inst: got %h want 00", inst); else passed++;
    checks++; if (cycle !== 3'd0) $display("FAIL reset_cycle: got %0d want 0", cycle); else passed++;
    checks++; if ({rst_o, nmi_o, irq_o} !== 3'b100) $display("FAIL reset_src: got %b want 100", {rst_o, nmi_o, irq_o}); else passed++;
    checks++; if (sync !== 1'b1) $display("FAIL reset_sync: got %b want 1", sync); else passed++;
    checks++; if (seq_err !== 1'b0) $display("FAIL reset_seq_err: got %b want 0", seq_err); else passed++;
    sinst = 1'b1; step(); sinst = 1'b0;
    checks++; if ({cycle, sync, rst_o} !== {3'd0, 1'b0, 1'b1}) $display("FAIL reset_sinst: got cyc=%0d sync=%b rst_o=%b want 0 0 1", cycle, sync, rst_o); else passed++;
    icyc = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      checks++; if (cycle !== 3'(i)) $display("FAIL reset_icyc_step: got %0d want %0d", cycle, i); else passed++;
    end
    icyc = 1'b0;
    checks++; if (seq_err !== 1'b0) $display("FAIL reset_no_wrap_err: got %b want 0", seq_err); else passed++;
    dbus = 8'hEA; rcyc = 1'b1; step(); rcyc = 1'b0;
    checks++; if ({inst, rst_o, sync} !== {8'hEA, 1'b0, 1'b1}) $display("FAIL reset_first_fetch: got inst=%h rst_o=%b sync=%b want ea 0 1", inst, rst_o, sync); else passed++;
  endtask

  task automatic test_fetch();
    dbus = 8'h69; rcyc = 1'b1; step(); rcyc = 1'b0;
    checks++; if ({inst, cycle, sync} !== {8'h69, 3'd0, 1'b1}) $display("FAIL fetch_op: got inst=%h cyc=%0d sync=%b want 69 0 1", inst, cycle, sync); else passed++;
    checks++; if ({rst_o, nmi_o, irq_o} !== 3'b000) $display("FAIL fetch_src: got %b want 000", {rst_o, nmi_o, irq_o}); else passed++;
    icyc = 1'b1; repeat (3) step(); icyc = 1'b0;
    checks++; if ({cycle, sync} !== {3'd3, 1'b0}) $display("FAIL fetch_icyc3: got cyc=%0d sync=%b want 3 0", cycle, sync); else passed++;
  endtask

  task automatic test_irq_mask();
    irq = 1'b1; iflag = 1'b1; dbus = 8'h69; rcyc = 1'b1; step();
    checks++; if ({inst, irq_o} !== {8'h69, 1'b0}) $display("FAIL irq_masked: got inst=%h irq_o=%b want 69 0", inst, irq_o); else passed++;
    iflag = 1'b0; step(); rcyc = 1'b0;
    checks++; if ({inst, irq_o, rst_o, nmi_o} !== {8'h00, 3'b100}) $display("FAIL irq_taken: got inst=%h irq/rst/nmi=%b want 00 100", inst, {irq_o, rst_o, nmi_o}); else passed++;
    irq = 1'b0; iflag = 1'b1; icyc = 1'b1; repeat (2) step(); icyc = 1'b0;
    checks++; if ({irq_o, cycle} !== {1'b1, 3'd2}) $display("FAIL irq_hold: got irq_o=%b cyc=%0d want 1 2", irq_o, cycle); else passed++;
    sinst = 1'b1; step(); sinst = 1'b0;
    checks++; if (irq_o !== 1'b1) $display("FAIL irq_sinst_noeffect: got %b want 1", irq_o); else passed++;
    dbus = 8'hA9; rcyc = 1'b1; step(); rcyc = 1'b0;
    checks++; if ({inst, irq_o} !== {8'hA9, 1'b0}) $display("FAIL irq_end: got inst=%h irq_o=%b want a9 0", inst, irq_o); else passed++;
  endtask

  task automatic test_nmi_priority();
    irq = 1'b1; iflag = 1'b0; nmi = 1'b1; step();
    checks++; if (nmi_o !== 1'b0) $display("FAIL nmi_not_early: got %b want 0", nmi_o); else passed++;
    rcyc = 1'b1; step(); rcyc = 1'b0;
    checks++; if ({nmi_o, irq_o, inst} !== {2'b10, 8'h00}) $display("FAIL nmi_over_irq: got nmi/irq=%b inst=%h want 10 00", {nmi_o, irq_o}, inst); else passed++;
    sinst = 1'b1; step(); sinst = 1'b0;
    rcyc = 1'b1; step(); rcyc = 1'b0;
    checks++; if ({nmi_o, irq_o} !== 2'b01) $display("FAIL nmi_then_irq: got %b want 01", {nmi_o, irq_o}); else passed++;
    nmi = 1'b0; step(); nmi = 1'b1; step();
    checks++; if ({nmi_o, irq_o} !== 2'b01) $display("FAIL nmi_during_irq_held: got %b want 01", {nmi_o, irq_o}); else passed++;
    irq = 1'b0; rcyc = 1'b1; step(); rcyc = 1'b0;
    checks++; if (nmi_o !== 1'b1) $display("FAIL nmi_after_irq: got %b want 1", nmi_o); else passed++;
    nmi = 1'b0; step();
    nmi = 1'b1; sinst = 1'b1; step(); sinst = 1'b0;
    rcyc = 1'b1; step(); rcyc = 1'b0;
    checks++; if (nmi_o !== 1'b1) $display("FAIL nmi_set_beats_clear: got %b want 1", nmi_o); else passed++;
    sinst = 1'b1; step(); sinst = 1'b0; nmi = 1'b0;
    dbus = 8'h69; rcyc = 1'b1; step(); rcyc = 1'b0;
    checks++; if ({nmi_o, inst} !== {1'b0, 8'h69}) $display("FAIL nmi_retired: got nmi_o=%b inst=%h want 0 69", nmi_o, inst); else passed++;
  endtask

  task automatic test_wrap();
    scyc = 1'b1; repeat (3) step();
    checks++; if ({cycle, seq_err} !== {3'd6, 1'b0}) $display("FAIL wrap_pre: got cyc=%0d err=%b want 6 0", cycle, seq_err); else passed++;
    step(); scyc = 1'b0;
    checks++; if ({cycle, seq_err} !== {3'd0, 1'b1}) $display("FAIL wrap_scyc: got cyc=%0d err=%b want 0 1", cycle, seq_err); else passed++;
    icyc = 1'b1; step(); icyc = 1'b0;
    checks++; if ({cycle, seq_err} !== {3'd1, 1'b1}) $display("FAIL wrap_sticky: got cyc=%0d err=%b want 1 1", cycle, seq_err); else passed++;
  endtask

  task automatic test_strobe_priority();
    dbus = 8'h4C; rcyc = 1'b1; scyc = 1'b1; icyc = 1'b1; step(); rcyc = 1'b0;
    checks++; if ({inst, cycle, sync} !== {8'h4C, 3'd0, 1'b1}) $display("FAIL prio_rcyc: got inst=%h cyc=%0d sync=%b want 4c 0 1", inst, cycle, sync); else passed++;
    step(); scyc = 1'b0; icyc = 1'b0;
    checks++; if (cycle !== 3'd2) $display("FAIL prio_scyc: got %0d want 2", cycle); else passed++;
  endtask

  task automatic test_rdy_freeze();
    rdy = 1'b0; icyc = 1'b1; repeat (2) step(); icyc = 1'b0;
    checks++; if ({cycle, sync} !== {3'd2, 1'b0}) $display("FAIL rdy_icyc: got cyc=%0d sync=%b want 2 0", cycle, sync); else passed++;
    dbus = 8'h11; rcyc = 1'b1; step(); rcyc = 1'b0;
    checks++; if (inst !== 8'h4C) $display("FAIL rdy_rcyc: got %h want 4c", inst); else passed++;
    nmi = 1'b1; step(); nmi = 1'b0; rdy = 1'b1;
    rcyc = 1'b1; step(); rcyc = 1'b0;
    checks++; if ({nmi_o, inst} !== {1'b1, 8'h00}) $display("FAIL rdy_nmi_latched: got nmi_o=%b inst=%h want 1 00", nmi_o, inst); else passed++;
    sinst = 1'b1; step(); sinst = 1'b0;
  endtask

  task automatic test_clr_mid();
    icyc = 1'b1; step(); icyc = 1'b0;
    clr = 1'b1; #1;
    checks++; if ({cycle, inst, rst_o, nmi_o, seq_err} !== {3'd0, 8'h00, 3'b100}) $display("FAIL clr_async: got cyc=%0d inst=%h rst/nmi/err=%b want 0 00 100", cycle, inst, {rst_o, nmi_o, seq_err}); else passed++;
    @(posedge clk); #1; clr = 1'b0;
    checks++; if (sync !== 1'b1) $display("FAIL clr_sync: got %b want 1", sync); else passed++;
  endtask

  task automatic test_idle();
    int n;
    sinst = 1'b1; step(); sinst = 1'b0;
    dbus = 8'h69; rcyc = 1'b1; step(); rcyc = 1'b0;
    checks++; if ({inst, rst_o} !== {8'h69, 1'b0}) $display("FAIL idle_setup: got inst=%h rst_o=%b want 69 0", inst, rst_o); else passed++;
`ifdef SEQ_WDOG_EN
    n = 0;
    while (n < 30) begin
      step(); n++;
      if (sync === 1'b1) break;
    end
    checks++; if (n !== 17) $display("FAIL wdog_clocks: got %0d want 17", n); else passed++;
    checks++; if ({inst, rst_o, cycle, seq_err} !== {8'h00, 1'b1, 3'd0, 1'b1}) $display("FAIL wdog_trip: got inst=%h rst_o=%b cyc=%0d err=%b want 00 1 0 1", inst, rst_o, cycle, seq_err); else passed++;
`else
    n = 0;
    repeat (40) begin step(); n++; end
    checks++; if ({inst, rst_o, cycle, sync, seq_err} !== {8'h69, 1'b0, 3'd0, 2'b00}) $display("FAIL idle_hold: got inst=%h rst_o=%b cyc=%0d sync=%b err=%b after %0d clocks", inst, rst_o, cycle, sync, seq_err, n); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_irq_mask();
    test_nmi_priority();
    test_wrap();
    test_strobe_priority();
    test_rdy_freeze();
    test_clr_mid();
    test_idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Owns the instruction register and the T-state (cycle) counter that drive the 6502 instruction decoder.
- Advances the cycle count on the decoder's icyc, scyc and rcyc strobes.
- Latches the next opcode from the data bus on rcyc, or forces the break opcode when an interrupt is pending.
- Latches and prioritises reset, NMI and IRQ, and presents one stable interrupt source to the decoder for the whole service sequence.

Parameters:
- CYC_W, 3: cycle counter width. Counter wraps modulo 2^CYC_W.
- INST_W, 8: opcode width.
- BRK_OP, 8'h00: opcode forced into inst when an interrupt is taken.
- WDOG_LIMIT, 16: idle clocks before a watchdog trip (used only with SEQ_WDOG_EN).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous reset, active-high.
- rdy  in  1  1 = advance; 0 = freeze sequencing state.
- dbus  in  INST_W  data bus; opcode is sampled from here on rcyc.
- icyc  in  1  decoder: increment the cycle.
- scyc  in  1  decoder: skip a cycle (cycle + 2).
- rcyc  in  1  decoder: instruction done; fetch the next one.
- sinst  in  1  decoder: interrupt service started; retire the source.
- irq  in  1  maskable interrupt request, level, active-high.
- nmi  in  1  non-maskable interrupt, rising-edge triggered.
- iflag  in  1  status I bit; 1 masks irq.
- inst  out  INST_W  current opcode to the decoder.
- cycle  out  CYC_W  current T-state to the decoder.
- rst_o  out  1  decoder clr input: a reset sequence is in progress.
- nmi_o  out  1  decoder nmi input.
- irq_o  out  1  decoder irq input.
- sync  out  1  high for the first clock of each new instruction.
- seq_err  out  1  sticky; cycle counter wrapped on icyc/scyc.

Behaviour:
- Reset (clr=1, asynchronous):
  - cycle=0, inst=BRK_OP, rst_pend=1, nmi_pend=0, int_src=RST.
  - Outputs: rst_o=1, nmi_o=0, irq_o=0, sync=1, seq_err=0.
  - All outputs are registered.
  - Result: the decoder begins the reset vector sequence from cycle 0 immediately after clr is released.
- Strobe priority when rdy=1: rcyc > scyc > icyc. Lower-priority strobes asserted in the same clock are ignored.
- rcyc:
  - cycle <= 0.
  - If rst_pend, nmi_pend, or (irq & ~iflag) is set: inst <= BRK_OP, and int_src is latched by priority RST > NMI > IRQ.
  - Otherwise: inst <= dbus, int_src = NONE.
  - sync=1 on the following clock only.
- scyc: cycle <= cycle+2. icyc: cycle <= cycle+1.
- Wrap on scyc/icyc: if the add overflows (e.g. cycle=7 with icyc), cycle wraps to the low bits and seq_err is set. seq_err clears only on clr.
- No strobe: all state holds.
- rst_o, nmi_o, irq_o are one-hot decodes of int_src. They are constant from rcyc until the next rcyc, even if irq drops or iflag changes mid-sequence.
- sinst: clears rst_pend if int_src=RST; clears nmi_pend if int_src=NMI. Has no effect for IRQ (level-sensitive) or NONE.
- NMI edge detection:
  - nmi is registered into nmi_q every clock, regardless of rdy.
  - nmi & ~nmi_q sets nmi_pend.
  - If a new edge coincides with sinst clearing nmi_pend, the set wins.
  - An NMI arriving during an IRQ sequence is held pending and taken at the next rcyc.
- rdy=0: cycle, inst, int_src, rst_pend and sync hold. NMI edge capture and clr remain active.
- clr asserted mid-instruction: immediate return to the reset state.

Optional Feature:
- Macro: SEQ_WDOG_EN.
- When defined:
  - An idle counter counts clocks with rdy=1 and no icyc, scyc or rcyc.
  - On reaching WDOG_LIMIT, the next clock performs a forced rcyc with rst_pend=1: inst=BRK_OP, int_src=RST, cycle=0, and seq_err is set.
  - The counter clears on any strobe or on clr.
- When undefined: the counter logic is absent, and the sequencer holds indefinitely with no strobes.

Decomposition:
- Shared package mos6502_pkg holds:
  - BRK_OP;
  - the int_src enum {NONE, RST, NMI, IRQ} (2 bits);
  - CYC_W and INST_W defaults.
- One natural sub-module: nmi_edge_det, containing the synchroniser register, rising-edge detect, and pending flag with set-over-clear priority.

Test Plan:
- Reset release: clr 1→0 → inst=8'h00, cycle=0, rst_o=1, sync=1. Then seven icyc pulses step cycle 0→7. A sinst in cycle 0 then clears rst_pend, so the following rcyc fetches from dbus.
- Normal fetch: dbus=8'h69, rcyc → next clock inst=8'h69, cycle=0, sync=1, rst_o=nmi_o=irq_o=0. Then icyc×3 → cycle=3.
- IRQ masking: irq=1, iflag=1, rcyc with dbus=8'h69 → inst=8'h69. Same with iflag=0 → inst=8'h00, irq_o=1. Dropping irq mid-sequence keeps irq_o=1 until the next rcyc.
- NMI vs IRQ priority: nmi 0→1 and irq=1 with iflag=0, then rcyc → nmi_o=1, irq_o=0. sinst clears nmi_pend, and the next rcyc takes the IRQ.
- Edge cases:
  - cycle=6 with scyc → cycle=0 and seq_err=1.
  - rcyc, scyc and icyc asserted together → rcyc result only.
  - rdy=0 with icyc → cycle unchanged.
  - An nmi edge during rdy=0 is still latched.
- SEQ_WDOG_EN defined, WDOG_LIMIT=16: 16 idle clocks → inst=8'h00, rst_o=1, cycle=0, seq_err=1.
